// File: rtl/spi_bus_pkg.sv
// rtl/spi_bus_pkg.sv - shared encodings for the SPI command/bus bridge
package spi_bus_pkg;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef enum logic [2:0] {
        FR_CMD,
        FR_ADDR_HI,
        FR_ADDR_LO,
        FR_DATA,
        FR_IGNORE
    } frame_state_t;

    typedef enum logic {
        BUS_IDLE,
        BUS_WAIT
    } bus_state_t;

    localparam int STAT_OVERRUN = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_BUSY    = 2;

    function automatic logic [7:0] make_stat(input logic busy, input logic tmo, input logic ovr);
        logic [7:0] s;
        s               = 8'h00;
        s[STAT_BUSY]    = busy;
        s[STAT_TIMEOUT] = tmo;
        s[STAT_OVERRUN] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/spi_bus_bridge_if.sv
// rtl/spi_bus_bridge_if.sv - byte-wide req/ack memory bus
interface spi_bus_bridge_if;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_req,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_req,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/spi_bus_master.sv
// rtl/spi_bus_master.sv - req/ack handshake with timeout and frame-tag filtering
module spi_bus_master
    import spi_bus_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue,
    input  logic                    issue_we,
    input  logic [15:0]             issue_addr,
    input  logic [7:0]              issue_wdata,
    input  logic                    frame_tag,
    spi_bus_bridge_if.master        bus,
    output logic                    busy,
    output logic                    rd_done,
    output logic                    rd_abort,
    output logic                    timeout,
    output logic [7:0]              rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bus_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              tag;
    logic              expired;
    logic              same_frame;

    // cnt counts cycles already spent in WAIT, so req stays high exactly TIMEOUT cycles
    assign expired    = (state == BUS_WAIT) && !bus.bus_ack && (cnt == CNT_W'(TIMEOUT - 1));
    assign same_frame = (tag == frame_tag);
    assign busy       = (state == BUS_WAIT);
    assign timeout    = expired;
    assign rd_done    = busy && bus.bus_ack && !bus.bus_we && same_frame;
    assign rd_abort   = expired && !bus.bus_we && same_frame;
    assign rdata      = bus.bus_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= BUS_IDLE;
            cnt           <= '0;
            tag           <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 16'h0000;
            bus.bus_wdata <= 8'h00;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (issue) begin
                        state         <= BUS_WAIT;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= issue_we;
                        bus.bus_addr  <= issue_addr;
                        bus.bus_wdata <= issue_wdata;
                        cnt           <= '0;
                        tag           <= frame_tag;
                    end
                end
                BUS_WAIT: begin
                    if (bus.bus_ack || expired) begin
                        state       <= BUS_IDLE;
                        bus.bus_req <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_bus_bridge.sv
// rtl/spi_bus_bridge.sv - SPI frame parser driving a byte-wide memory bus
module spi_bus_bridge
    import spi_bus_pkg::*;
#(
    parameter int         TIMEOUT   = 64,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        mdata,
    input  logic              data_valid,
    input  logic              data_first,
    output logic [7:0]        sdata,
    spi_bus_bridge_if.master  bus,
    input  logic              err_clr,
    output logic              err_overrun,
    output logic              err_timeout
);

    frame_state_t state;
    logic         is_read;
    logic [15:0]  addr;
    logic         frame_tag;
    logic [7:0]   stat;
    logic         take_cmd;
    logic         issue;
    logic         issue_we;
    logic [15:0]  issue_addr;
    logic         busy;
    logic         rd_done;
    logic         rd_abort;
    logic         timeout;
    logic [7:0]   rdata;

    assign stat     = make_stat(bus.bus_req, err_timeout, err_overrun);
    assign take_cmd = data_valid && (data_first || (state == FR_CMD));

    // Reads run one address ahead so the byte lands in sdata before it is shifted out
    always_comb begin
        issue      = 1'b0;
        issue_we   = 1'b0;
        issue_addr = addr;
        if (data_valid && !take_cmd) begin
            case (state)
                FR_ADDR_LO: begin
                    if (is_read) begin
                        issue      = 1'b1;
                        issue_addr = {addr[15:8], mdata};
                    end
                end
                FR_DATA: begin
                    issue      = 1'b1;
                    issue_we   = !is_read;
                    issue_addr = is_read ? addr + 16'd1 : addr;
                end
                default: ;
            endcase
        end
    end

    spi_bus_master #(.TIMEOUT(TIMEOUT)) u_master (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue && !busy),
        .issue_we    (issue_we),
        .issue_addr  (issue_addr),
        .issue_wdata (mdata),
        .frame_tag   (frame_tag),
        .bus         (bus),
        .busy        (busy),
        .rd_done     (rd_done),
        .rd_abort    (rd_abort),
        .timeout     (timeout),
        .rdata       (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FR_CMD;
            is_read     <= 1'b0;
            addr        <= 16'h0000;
            frame_tag   <= 1'b0;
            sdata       <= 8'h00;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (rd_done) begin
                sdata <= rdata;
            end else if (rd_abort) begin
                sdata <= FILL_BYTE;
            end

            // Frame-side sdata writes come last so a new frame's status beats late bus results
            if (take_cmd) begin
                if (data_first) begin
                    frame_tag <= ~frame_tag;
                end
                if ((mdata == CMD_READ) || (mdata == CMD_WRITE)) begin
                    is_read <= (mdata == CMD_READ);
                    state   <= FR_ADDR_HI;
                    sdata   <= stat;
                end else begin
                    state <= FR_IGNORE;
                    sdata <= FILL_BYTE;
                end
            end else if (data_valid) begin
                case (state)
                    FR_ADDR_HI: begin
                        addr[15:8] <= mdata;
                        sdata      <= stat;
                        state      <= FR_ADDR_LO;
                    end
                    FR_ADDR_LO: begin
                        addr[7:0] <= mdata;
                        state     <= FR_DATA;
                        if (!is_read) begin
                            sdata <= stat;
                        end
                    end
                    FR_DATA: addr <= addr + 16'd1;
                    default: ;
                endcase
            end

            err_overrun <= (issue && busy) | (err_overrun & ~err_clr);
            err_timeout <= timeout | (err_timeout & ~err_clr);
        end
    end

endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb/tb_spi_bus_bridge.sv - self-checking bench for spi_bus_bridge
module tb_spi_bus_bridge;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mdata = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_first = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] sdata;
    logic       err_overrun;
    logic       err_timeout;

    spi_bus_bridge_if bus();

    spi_bus_bridge #(.TIMEOUT(TMO), .FILL_BYTE(8'hFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .mdata       (mdata),
        .data_valid  (data_valid),
        .data_first  (data_first),
        .sdata       (sdata),
        .bus         (bus),
        .err_clr     (err_clr),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } acc_t;

    typedef struct {
        logic [7:0][7:0] b;
        int              len;
        int              dly;
        int              n;
        logic [15:0]     a0;
        logic [15:0]     alast;
        logic            we;
        logic [7:0]      d0;
        logic [7:0]      dlast;
        logic [7:0][7:0] sd;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    acc_t       acc_q[$];
    int         ack_delay = 2;
    bit         ack_en = 1'b1;
    int         req_run = 0;
    int         last_req_len = 0;
    vec_t       vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][7:0] bytes8(input logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7);
        logic [7:0][7:0] r;
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
        r[4] = x4; r[5] = x5; r[6] = x6; r[7] = x7;
        return r;
    endfunction

    task automatic set_vec(input int i, input logic [7:0][7:0] b, input int len, input int dly,
                           input int n, input logic [15:0] a0, input logic [15:0] alast,
                           input logic we, input logic [7:0] d0, input logic [7:0] dlast,
                           input logic [7:0][7:0] sd);
        vt[i].b = b; vt[i].len = len; vt[i].dly = dly; vt[i].n = n;
        vt[i].a0 = a0; vt[i].alast = alast; vt[i].we = we;
        vt[i].d0 = d0; vt[i].dlast = dlast; vt[i].sd = sd;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic first, input int gap);
        @(posedge clk); #1;
        mdata = b; data_valid = 1'b1; data_first = first;
        @(posedge clk); #1;
        data_valid = 1'b0; data_first = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after ack_delay cycles unless the request vanished
    initial begin : responder
        acc_t a;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.bus_req && ack_en) begin
                repeat (ack_delay - 1) begin
                    @(posedge clk); #1;
                end
                if (bus.bus_req && ack_en) begin
                    a.addr = bus.bus_addr;
                    a.we   = bus.bus_we;
                    if (a.we) begin
                        mem[a.addr] = bus.bus_wdata;
                        a.data      = bus.bus_wdata;
                    end else begin
                        a.data = mem[a.addr];
                    end
                    bus.bus_rdata = a.data;
                    bus.bus_ack   = 1'b1;
                    acc_q.push_back(a);
                    @(posedge clk); #1;
                    bus.bus_ack = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.bus_req) begin
            req_run++;
        end else begin
            if (req_run != 0) last_req_len = req_run;
            req_run = 0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0]  fb[$];
        logic [7:0]  exp_sd[$];
        acc_t        exp_q[$];
        int          len;
        int          r;
        logic [15:0] a;
        logic [15:0] ad;
        logic [7:0]  cmd;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33;
        mem[16'h0013] = 8'h44; mem[16'h0014] = 8'h55;

        set_vec(0, bytes8(8'h01, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00), 5, 2,
                2, 16'h1234, 16'h1235, 1'b1, 8'hAA, 8'hBB, '0);
        set_vec(1, bytes8(8'h01, 8'hFF, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00), 5, 3,
                2, 16'hFFFF, 16'h0000, 1'b1, 8'h5A, 8'hA5, '0);
        set_vec(2, bytes8(8'h00, 8'h00, 8'h10, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'h00), 7, 2,
                5, 16'h0010, 16'h0014, 1'b0, 8'h11, 8'h55,
                bytes8(8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00));
        set_vec(3, bytes8(8'h80, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00), 4, 1,
                0, 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00,
                bytes8(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00));
        set_vec(4, bytes8(8'h01, 8'h00, 8'h40, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00), 4, 1,
                1, 16'h0040, 16'h0040, 1'b1, 8'hC3, 8'hC3, '0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_sdata", sdata, 8'h00);
        check("rst_req", bus.bus_req, 1'b0);
        check("rst_we", bus.bus_we, 1'b0);
        check("rst_addr", bus.bus_addr, 16'h0000);
        check("rst_wdata", bus.bus_wdata, 8'h00);
        check("rst_ovr", err_overrun, 1'b0);
        check("rst_tmo", err_timeout, 1'b0);
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            acc_q.delete();
            ack_delay = vt[v].dly;
            for (int i = 0; i < vt[v].len; i++) begin
                send_byte(vt[v].b[i], i == 0, 14);
                check($sformatf("v%0d_sdata%0d", v, i), sdata, vt[v].sd[i]);
            end
            check($sformatf("v%0d_nacc", v), acc_q.size(), vt[v].n);
            if (vt[v].n > 0 && acc_q.size() == vt[v].n) begin
                check($sformatf("v%0d_a0", v), acc_q[0].addr, vt[v].a0);
                check($sformatf("v%0d_alast", v), acc_q[vt[v].n-1].addr, vt[v].alast);
                check($sformatf("v%0d_we0", v), acc_q[0].we, vt[v].we);
                check($sformatf("v%0d_welast", v), acc_q[vt[v].n-1].we, vt[v].we);
                check($sformatf("v%0d_d0", v), acc_q[0].data, vt[v].d0);
                check($sformatf("v%0d_dlast", v), acc_q[vt[v].n-1].data, vt[v].dlast);
            end
        end

        // Timeout followed by an overrun on the same write burst
        ack_en = 1'b0;
        acc_q.delete();
        send_byte(8'h01, 1'b1, 4);
        send_byte(8'h00, 1'b0, 4);
        send_byte(8'h20, 1'b0, 4);
        send_byte(8'hD1, 1'b0, 2);
        send_byte(8'hD2, 1'b0, 2);
        check("ovr_set", err_overrun, 1'b1);
        check("tmo_not_yet", err_timeout, 1'b0);
        for (int k = 0; k < 40 && !err_timeout; k++) @(posedge clk);
        #1;
        check("tmo_set", err_timeout, 1'b1);
        check("tmo_req_low", bus.bus_req, 1'b0);
        check("tmo_req_len", last_req_len, TMO);
        check("tmo_no_ack", acc_q.size(), 0);
        ack_en = 1'b1;
        send_byte(8'hD3, 1'b0, 14);
        check("tmo_next_n", acc_q.size(), 1);
        if (acc_q.size() == 1) begin
            check("tmo_next_addr", acc_q[0].addr, 16'h0022);
            check("tmo_next_data", acc_q[0].data, 8'hD3);
        end
        send_byte(8'h01, 1'b1, 14);
        check("stat_errs", sdata, 8'h03);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        check("clr_ovr", err_overrun, 1'b0);
        check("clr_tmo", err_timeout, 1'b0);

        // Randomized frames against a frame-level reference model
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int f = 0; f < 20; f++) begin
            r   = $urandom_range(0, 9);
            cmd = (r < 4) ? 8'h00 : (r < 8) ? 8'h01 : 8'($urandom_range(2, 255));
            a   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            len = $urandom_range(3, 7);
            ack_delay = $urandom_range(1, 4);
            fb.delete(); exp_sd.delete(); exp_q.delete();
            fb.push_back(cmd); fb.push_back(a[15:8]); fb.push_back(a[7:0]);
            for (int i = 3; i < len; i++) fb.push_back(8'($urandom));
            for (int i = 0; i < len; i++) begin
                if (cmd > 8'h01) begin
                    exp_sd.push_back(8'hFF);
                end else if (i < 2) begin
                    exp_sd.push_back(8'h00);
                end else if (cmd == 8'h00) begin
                    ad = a + 16'(i - 2);
                    exp_sd.push_back(ref_mem[ad]);
                    exp_q.push_back(acc_t'{ad, 1'b0, ref_mem[ad]});
                end else begin
                    exp_sd.push_back(8'h00);
                    if (i >= 3) begin
                        ad = a + 16'(i - 3);
                        ref_mem[ad] = fb[i];
                        exp_q.push_back(acc_t'{ad, 1'b1, fb[i]});
                    end
                end
            end
            acc_q.delete();
            for (int i = 0; i < len; i++) begin
                send_byte(fb[i], i == 0, 14);
                check($sformatf("rnd%0d_sdata%0d", f, i), sdata, exp_sd[i]);
            end
            check($sformatf("rnd%0d_nacc", f), acc_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
                check($sformatf("rnd%0d_addr%0d", f, k), acc_q[k].addr, exp_q[k].addr);
                check($sformatf("rnd%0d_we%0d", f, k), acc_q[k].we, exp_q[k].we);
                check($sformatf("rnd%0d_data%0d", f, k), acc_q[k].data, exp_q[k].data);
            end
        end

        // Asynchronous reset while a request is outstanding
        ack_en = 1'b0;
        send_byte(8'h01, 1'b1, 4);
        send_byte(8'h00, 1'b0, 4);
        send_byte(8'h50, 1'b0, 4);
        send_byte(8'h77, 1'b0, 2);
        check("arst_req_before", bus.bus_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_req", bus.bus_req, 1'b0);
        check("arst_sdata", sdata, 8'h00);
        check("arst_addr", bus.bus_addr, 16'h0000);
        check("arst_we", bus.bus_we, 1'b0);
        check("arst_wdata", bus.bus_wdata, 8'h00);
        check("arst_ovr", err_overrun, 1'b0);
        check("arst_tmo", err_timeout, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        ack_en = 1'b1;
        acc_q.delete();
        send_byte(8'h01, 1'b1, 14);
        send_byte(8'h00, 1'b0, 14);
        send_byte(8'h60, 1'b0, 14);
        send_byte(8'h99, 1'b0, 14);
        check("arst_next_n", acc_q.size(), 1);
        if (acc_q.size() == 1) begin
            check("arst_next_addr", acc_q[0].addr, 16'h0060);
            check("arst_next_data", acc_q[0].data, 8'h99);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
